// File: rtl/vector_wb_pkg.sv
// Shared types and constants for the vector writeback stage.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package vector_wb_pkg;

    localparam int VECTOR_REGISTERS = 32;
    localparam int VECTOR_LANES     = 8;
    localparam int XLEN             = 32;
    localparam int AW               = $clog2(VECTOR_REGISTERS);

    // Bit positions inside the 5-bit fflags vector (NV is the MSB).
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    typedef struct packed {
        logic [VECTOR_LANES-1:0]      en;
        logic [AW-1:0]                addr;
        logic [VECTOR_LANES*XLEN-1:0] data;
    } vector_wb_req_t;

    // A request with no lane enabled writes nothing and completes nothing.
    function automatic logic req_active(input vector_wb_req_t r);
        return |r.en;
    endfunction

endpackage

// File: rtl/vector_wb_fifo.sv
// Synchronous FIFO of vmu writeback requests.
// Latency: head visible the cycle after push; pop consumes the head in the same cycle.
// Backpressure: full_o is a decode of the registered count; the caller must not push when full.
module vector_wb_fifo
    import vector_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  vector_wb_req_t wdata_i,
    input  logic           pop_i,
    output vector_wb_req_t rdata_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [CW-1:0]  count_o
);

    vector_wb_req_t mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q;

    // Storage carries no reset; validity is tracked by count/pointers only.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            if (push_i && !pop_i)      count_q <= count_q + 1'b1;
            else if (pop_i && !push_i) count_q <= count_q - 1'b1;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/vector_wb.sv
// Vector writeback: arbitrates vex results and buffered vmu loads onto the single VRF write port.
// Latency: 1 cycle from an accepted/selected request to the registered VRF write and wb_done pulse.
// Backpressure: vex never stalls and always wins; vmu is held off only when the load FIFO is full.
module vector_wb
    import vector_wb_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [VECTOR_LANES-1:0]      vex_wr_en_i,
    input  logic [AW-1:0]                vex_wr_addr_i,
    input  logic [VECTOR_LANES*XLEN-1:0] vex_wr_data_i,
    input  logic [4:0]                   vex_fflags_i,
    input  logic                         ld_valid_i,
    output logic                         ld_ready_o,
    input  logic [VECTOR_LANES-1:0]      ld_wr_en_i,
    input  logic [AW-1:0]                ld_wr_addr_i,
    input  logic [VECTOR_LANES*XLEN-1:0] ld_wr_data_i,
    output logic [VECTOR_LANES-1:0]      vrf_wr_en_o,
    output logic [AW-1:0]                vrf_wr_addr_o,
    output logic [VECTOR_LANES*XLEN-1:0] vrf_wr_data_o,
    output logic                         wb_done_o,
    output logic [AW-1:0]                wb_done_reg_o,
    output logic [4:0]                   fflags_o,
    input  logic                         fflags_clr_i,
    output logic                         wb_idle_o
);

    localparam int CW = $clog2(LD_FIFO_DEPTH) + 1;

    vector_wb_req_t vex_req, ld_req, head, sel;
    logic           vex_vld, ld_acc, bypass, push, pop, sel_vld, wr_vld;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;

    logic [VECTOR_LANES-1:0]      vrf_en_q, vrf_en_d;
    logic [AW-1:0]                vrf_addr_q, vrf_addr_d;
    logic [VECTOR_LANES*XLEN-1:0] vrf_data_q, vrf_data_d;
    logic                         done_q, done_d;
    logic [4:0]                   fflags_q, fflags_d;

    assign vex_req = '{en: vex_wr_en_i, addr: vex_wr_addr_i, data: vex_wr_data_i};
    assign ld_req  = '{en: ld_wr_en_i,  addr: ld_wr_addr_i,  data: ld_wr_data_i};
    assign vex_vld = |vex_wr_en_i;

    // Ready comes from the registered count only, so a same-cycle pop never reopens it.
    assign ld_ready_o = !fifo_full;
    assign ld_acc     = ld_valid_i && ld_ready_o;
    // Bypass only when nothing older is queued, which keeps vmu writes in order.
    assign bypass     = !vex_vld && fifo_empty && ld_acc;
    assign pop        = !vex_vld && !fifo_empty;
    // Empty-lane loads are acknowledged but never occupy a FIFO slot.
    assign push       = ld_acc && !bypass && req_active(ld_req);

    vector_wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (ld_req),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Source select: vex first, then the FIFO head, then a bypassed load.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        if (vex_vld) begin
            sel     = vex_req;
            sel_vld = 1'b1;
        end else if (pop) begin
            sel     = head;
            sel_vld = 1'b1;
        end else if (bypass) begin
            sel     = ld_req;
            sel_vld = 1'b1;
        end
    end

    // Next state of the write port and flags; address/data hold when nothing is written.
    always_comb begin
        wr_vld     = sel_vld && req_active(sel);
        vrf_en_d   = wr_vld ? sel.en : '0;
        done_d     = wr_vld;
        vrf_addr_d = wr_vld ? sel.addr : vrf_addr_q;
        vrf_data_d = wr_vld ? sel.data : vrf_data_q;
        fflags_d   = fflags_clr_i ? 5'b0 : fflags_q;
        if (vex_vld) fflags_d = fflags_d | vex_fflags_i;
    end

    // Output registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vrf_en_q   <= '0;
            vrf_addr_q <= '0;
            vrf_data_q <= '0;
            done_q     <= 1'b0;
            fflags_q   <= '0;
        end else begin
            vrf_en_q   <= vrf_en_d;
            vrf_addr_q <= vrf_addr_d;
            vrf_data_q <= vrf_data_d;
            done_q     <= done_d;
            fflags_q   <= fflags_d;
        end
    end

    assign vrf_wr_en_o   = vrf_en_q;
    assign vrf_wr_addr_o = vrf_addr_q;
    assign vrf_wr_data_o = vrf_data_q;
    assign wb_done_o     = done_q;
    assign wb_done_reg_o = vrf_addr_q;
    assign fflags_o      = fflags_q;
    assign wb_idle_o     = (fifo_count == '0) && !(|vrf_en_q);

endmodule

// File: tb/tb_vector_wb.sv
// Directed-vector bench for vector_wb.
// Latency: checks registered outputs one cycle after the driving cycle.
// Backpressure: exercises FIFO fill, full stall, drain and ordering.
module tb_vector_wb;
    import vector_wb_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [VECTOR_LANES-1:0]      vex_wr_en_i = '0;
    logic [AW-1:0]                vex_wr_addr_i = '0;
    logic [VECTOR_LANES*XLEN-1:0] vex_wr_data_i = '0;
    logic [4:0]                   vex_fflags_i = '0;
    logic                         ld_valid_i = 1'b0;
    logic                         ld_ready_o;
    logic [VECTOR_LANES-1:0]      ld_wr_en_i = '0;
    logic [AW-1:0]                ld_wr_addr_i = '0;
    logic [VECTOR_LANES*XLEN-1:0] ld_wr_data_i = '0;
    logic [VECTOR_LANES-1:0]      vrf_wr_en_o;
    logic [AW-1:0]                vrf_wr_addr_o;
    logic [VECTOR_LANES*XLEN-1:0] vrf_wr_data_o;
    logic                         wb_done_o;
    logic [AW-1:0]                wb_done_reg_o;
    logic [4:0]                   fflags_o;
    logic                         fflags_clr_i = 1'b0;
    logic                         wb_idle_o;

    int n_vec  = 0;
    int n_miss = 0;

    vector_wb dut (
        .clk(clk), .rst_n(rst_n),
        .vex_wr_en_i(vex_wr_en_i), .vex_wr_addr_i(vex_wr_addr_i),
        .vex_wr_data_i(vex_wr_data_i), .vex_fflags_i(vex_fflags_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .ld_wr_en_i(ld_wr_en_i), .ld_wr_addr_i(ld_wr_addr_i), .ld_wr_data_i(ld_wr_data_i),
        .vrf_wr_en_o(vrf_wr_en_o), .vrf_wr_addr_o(vrf_wr_addr_o), .vrf_wr_data_o(vrf_wr_data_o),
        .wb_done_o(wb_done_o), .wb_done_reg_o(wb_done_reg_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .wb_idle_o(wb_idle_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkdat(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(a);
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vex_set(input logic [7:0] en, input int a, input logic [4:0] fl);
        vex_wr_en_i   = en;
        vex_wr_addr_i = AW'(a);
        vex_wr_data_i = mkdat(a);
        vex_fflags_i  = fl;
    endtask

    task automatic ld_set(input logic v, input logic [7:0] en, input int a);
        ld_valid_i   = v;
        ld_wr_en_i   = en;
        ld_wr_addr_i = AW'(a);
        ld_wr_data_i = mkdat(a);
    endtask

    // Expect a VRF write of register a with lane mask en in the current cycle.
    task automatic exp_wr(input string tag, input logic [7:0] en, input int a);
        chk({tag, "_en"},   256'(vrf_wr_en_o),   256'(en));
        chk({tag, "_addr"}, 256'(vrf_wr_addr_o), 256'(a));
        chk({tag, "_done"}, 256'(wb_done_o),     256'(1));
        chk({tag, "_dreg"}, 256'(wb_done_reg_o), 256'(a));
        chk({tag, "_data"}, vrf_wr_data_o,       mkdat(a));
    endtask

    task automatic exp_none(input string tag);
        chk({tag, "_en"},   256'(vrf_wr_en_o), 256'(0));
        chk({tag, "_done"}, 256'(wb_done_o),   256'(0));
    endtask

    task automatic exp_reset_outputs(input string tag);
        exp_none(tag);
        chk({tag, "_addr"}, 256'(vrf_wr_addr_o), 256'(0));
        chk({tag, "_data"}, vrf_wr_data_o,       256'(0));
        chk({tag, "_dreg"}, 256'(wb_done_reg_o), 256'(0));
        chk({tag, "_ff"},   256'(fflags_o),      256'(0));
        chk({tag, "_rdy"},  256'(ld_ready_o),    256'(1));
        chk({tag, "_idle"}, 256'(wb_idle_o),     256'(1));
    endtask

    initial begin
        int k;
        // Reset state
        #12;
        exp_reset_outputs("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        exp_reset_outputs("post_rst");

        // vex-only stream v1,v2,v3
        for (int i = 1; i <= 3; i++) begin
            vex_set(8'hFF, i, 5'b0);
            tick();
            exp_wr($sformatf("vex%0d", i), 8'hFF, i);
        end
        vex_set(8'h00, 9, 5'b0);
        tick();
        exp_none("vex_idle");
        chk("vex_hold_addr", 256'(vrf_wr_addr_o), 256'(3));
        chk("vex_idle_flag", 256'(wb_idle_o), 256'(1));

        // Bypass: FIFO empty, vex idle
        ld_set(1'b1, 8'h0F, 5);
        ld_wr_data_i = {8{32'h5A5A_5A5A}};
        chk("byp_rdy", 256'(ld_ready_o), 256'(1));
        tick();
        ld_set(1'b0, 8'h00, 0);
        chk("byp_en",   256'(vrf_wr_en_o),   256'(8'h0F));
        chk("byp_addr", 256'(vrf_wr_addr_o), 256'(5));
        chk("byp_data", vrf_wr_data_o,       {8{32'h5A5A_5A5A}});
        chk("byp_busy", 256'(wb_idle_o),     256'(0));
        tick();
        exp_none("byp_after");
        chk("byp_fifo_empty", 256'(wb_idle_o), 256'(1));

        // Contention: 6 vex writes, vmu pushing every cycle
        k = 0;
        for (int i = 0; i < 6; i++) begin
            vex_set(8'hFF, 20 + i, 5'b0);
            ld_set(1'b1, 8'h33, 10 + k);
            chk($sformatf("cont_rdy%0d", i), 256'(ld_ready_o), 256'(i < 4));
            if (i < 4) k++;
            tick();
            exp_wr($sformatf("cont_vex%0d", i), 8'hFF, 20 + i);
        end
        vex_set(8'h00, 0, 5'b0);
        ld_set(1'b0, 8'h00, 0);
        chk("cont_full_rdy", 256'(ld_ready_o), 256'(0));
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_wr($sformatf("drain%0d", j), 8'h33, 10 + j);
            chk($sformatf("drain_rdy%0d", j), 256'(ld_ready_o), 256'(1));
        end
        tick();
        exp_none("drain_end");
        chk("drain_idle", 256'(wb_idle_o), 256'(1));

        // Ordering: two queued entries, then a new load with vex idle
        for (int i = 0; i < 2; i++) begin
            vex_set(8'hFF, 24 + i, 5'b0);
            ld_set(1'b1, 8'h03, 16 + i);
            tick();
            exp_wr($sformatf("ord_vex%0d", i), 8'hFF, 24 + i);
        end
        vex_set(8'h00, 0, 5'b0);
        ld_set(1'b1, 8'h03, 18);
        tick();
        ld_set(1'b0, 8'h00, 0);
        exp_wr("ord_a", 8'h03, 16);
        tick();
        exp_wr("ord_b", 8'h03, 17);
        tick();
        exp_wr("ord_c", 8'h03, 18);
        chk("ord_busy", 256'(wb_idle_o), 256'(0));
        tick();
        exp_none("ord_end");
        chk("ord_idle", 256'(wb_idle_o), 256'(1));

        // All-zero lane enables: dropped, vmu still handshakes
        ld_set(1'b1, 8'h00, 7);
        chk("drop_rdy", 256'(ld_ready_o), 256'(1));
        tick();
        ld_set(1'b0, 8'h00, 0);
        exp_none("drop_ld");
        chk("drop_hold", 256'(vrf_wr_addr_o), 256'(18));
        tick();
        chk("drop_idle", 256'(wb_idle_o), 256'(1));

        // fflags accumulate, clear-with-new, clear alone
        vex_set(8'h01, 2, 5'b00001);
        tick();
        chk("ff_a", 256'(fflags_o), 256'(5'b00001));
        vex_set(8'h01, 2, 5'b10000);
        tick();
        chk("ff_b", 256'(fflags_o), 256'(5'b10001));
        vex_set(8'h01, 2, 5'b00100);
        fflags_clr_i = 1'b1;
        tick();
        chk("ff_clr_new", 256'(fflags_o), 256'(5'b00100));
        vex_set(8'h00, 2, 5'b01000);
        tick();
        fflags_clr_i = 1'b0;
        chk("ff_clr_only", 256'(fflags_o), 256'(0));
        vex_set(8'h00, 2, 5'b01000);
        tick();
        chk("ff_novex", 256'(fflags_o), 256'(0));

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            vex_set(8'hFF, 26 + i, 5'b00010);
            ld_set(1'b1, 8'hF0, 29 + i);
            tick();
        end
        vex_set(8'h00, 0, 5'b0);
        ld_set(1'b0, 8'h00, 0);
        chk("prerst_busy", 256'(wb_idle_o), 256'(0));
        #2;
        rst_n = 1'b0;
        #1;
        exp_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_none($sformatf("after_rst%0d", i));
            chk($sformatf("after_rst_idle%0d", i), 256'(wb_idle_o), 256'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
